// File: rtl/usb_rw_burst_ctrl_pkg.sv
// Shared constants, enums and token packing for the USB page read/write controller.
package usb_rw_pkg;

  localparam logic [7:0] PID_OUT   = 8'b10000111;
  localparam logic [7:0] PID_IN    = 8'b10010110;
  localparam logic [7:0] PID_DATA0 = 8'b11000011;

  typedef enum logic [1:0] {
    TASK_IDLE  = 2'b00,
    TASK_READ  = 2'b01,
    TASK_WRITE = 2'b10
  } task_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_WR,
    S_DATA,
    S_DONE
  } state_e;

  function automatic logic [18:0] make_token(input logic [7:0] pid,
                                             input logic [6:0] addr,
                                             input logic [3:0] endp);
    return {pid, addr, endp};
  endfunction

endpackage

// File: rtl/usb_rw_burst_ctrl_if.sv
// Task-side and protocol-side signal bundle of the burst controller.
interface usb_rw_burst_ctrl_if #(
  parameter int DATA_BYTES = 8,
  parameter int PAGE_W     = 16,
  parameter int MAX_PAGES  = 16,
  parameter int MAX_RETRY  = 3
);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int CNT_W = $clog2(MAX_PAGES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  logic [1:0]             task_i;
  logic                   start;
  logic [PAGE_W-1:0]      mempage;
  logic [CNT_W-1:0]       num_pages;
  logic [DW-1:0]          wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   ptcl_ready;
  logic                   ptcl_done;
  logic                   ptcl_success;
  logic [DW-1:0]          ptcl_data;
  logic [18:0]            token_pkt_out;
  logic [8+DW-1:0]        data_pkt_out;
  logic                   data_avail;
  logic [DW-1:0]          rd_data;
  logic                   rd_valid;
  logic                   busy;
  logic                   task_done;
  logic                   task_success;
  logic [RTY_W+CNT_W-1:0] fail_count;

  modport master (
    output task_i, start, mempage, num_pages, wr_data, wr_valid,
           ptcl_ready, ptcl_done, ptcl_success, ptcl_data,
    input  wr_ready, token_pkt_out, data_pkt_out, data_avail, rd_data,
           rd_valid, busy, task_done, task_success, fail_count
  );

  modport slave (
    input  task_i, start, mempage, num_pages, wr_data, wr_valid,
           ptcl_ready, ptcl_done, ptcl_success, ptcl_data,
    output wr_ready, token_pkt_out, data_pkt_out, data_avail, rd_data,
           rd_valid, busy, task_done, task_success, fail_count
  );
endinterface

// File: rtl/usb_rw_burst_ctrl_bitrev.sv
// Combinational full-width bit reversal: bit i moves to bit W-1-i.
module bit_reverse_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  for (genvar g = 0; g < W; g++) begin : g_rev
    assign o_q[g] = i_d[W-1-g];
  end
endmodule

// File: rtl/usb_rw_burst_ctrl.sv
// Host-side USB page read/write controller: multi-page bursts of address and
// data phases with per-phase bounded retry, write handshake and read strobe.
module usb_rw_burst_ctrl
  import usb_rw_pkg::*;
#(
  parameter int         DATA_BYTES = 8,
  parameter int         PAGE_W     = 16,
  parameter int         MAX_PAGES  = 16,
  parameter int         MAX_RETRY  = 3,
  parameter logic [6:0] DEV_ADDR   = 7'b1010000,
  parameter logic [3:0] ENDP_ADDR  = 4'b0010,
  parameter logic [3:0] ENDP_DATA  = 4'b0001
) (
  input logic                clk,
  input logic                rst,
  usb_rw_burst_ctrl_if.slave bus
);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int CNT_W = $clog2(MAX_PAGES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int FC_W  = RTY_W + CNT_W;

  state_e            r_state, w_next;
  task_e             r_task;
  logic [PAGE_W-1:0] r_cur_page;
  logic [CNT_W-1:0]  r_pages_left;
  logic [RTY_W-1:0]  r_retry;
  logic [FC_W-1:0]   r_fail_cnt;
  logic [DW-1:0]     r_wr_reg, r_rd_data;
  logic              r_rd_valid, r_gap, r_result, w_result_nxt;

  logic          w_in_phase, w_ok, w_fail, w_task_valid, w_can_retry, w_last;
  logic          w_avail, w_rd_data_phase, w_start_ok;
  logic [DW-1:0] w_rev_in, w_rev_out;
  logic          w_unused;

  assign w_unused        = bus.ptcl_ready;
  assign w_in_phase      = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_ok            = w_in_phase && bus.ptcl_done && bus.ptcl_success;
  assign w_fail          = w_in_phase && bus.ptcl_done && !bus.ptcl_success;
  assign w_task_valid    = (bus.task_i == TASK_READ) || (bus.task_i == TASK_WRITE);
  assign w_start_ok      = (r_state == S_IDLE) && bus.start && w_task_valid;
  assign w_can_retry     = r_retry < RTY_W'(MAX_RETRY);
  assign w_last          = r_pages_left == CNT_W'(1);
  assign w_rd_data_phase = (r_state == S_DATA) && (r_task == TASK_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          if (bus.num_pages == '0) begin
            w_next       = S_DONE;
            w_result_nxt = 1'b0;
          end else begin
            w_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (w_ok) begin
          w_next = (r_task == TASK_WRITE) ? S_WAIT_WR : S_DATA;
        end else if (w_fail && !w_can_retry) begin
          w_next       = S_DONE;
          w_result_nxt = 1'b0;
        end
      end
      S_WAIT_WR: begin
        if (bus.wr_valid) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_ok) begin
          if (w_last) begin
            w_next       = S_DONE;
            w_result_nxt = 1'b1;
          end else begin
            w_next = S_ADDR;
          end
        end else if (w_fail && !w_can_retry) begin
          w_next       = S_DONE;
          w_result_nxt = 1'b0;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping, payload capture and failure accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_task       <= TASK_IDLE;
      r_cur_page   <= '0;
      r_pages_left <= '0;
      r_retry      <= '0;
      r_fail_cnt   <= '0;
      r_wr_reg     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_gap        <= 1'b0;
    end else begin
      r_gap      <= bus.ptcl_done;
      r_rd_valid <= 1'b0;
      if (w_start_ok) begin
        r_task       <= task_e'(bus.task_i);
        r_cur_page   <= bus.mempage;
        r_pages_left <= bus.num_pages;
        r_fail_cnt   <= '0;
        r_retry      <= '0;
      end
      if ((r_state == S_WAIT_WR) && bus.wr_valid) r_wr_reg <= bus.wr_data;
      if (w_ok) begin
        r_retry <= '0;
        if (r_state == S_DATA) begin
          r_pages_left <= r_pages_left - CNT_W'(1);
          r_cur_page   <= r_cur_page + PAGE_W'(1);
          if (r_task == TASK_READ) begin
            r_rd_data  <= bus.ptcl_data;
            r_rd_valid <= 1'b1;
          end
        end
      end
      if (w_fail) begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + FC_W'(1);
        if (w_can_retry) r_retry <= r_retry + RTY_W'(1);
      end
    end
  end

  // Address phases carry the page left-aligned; write data phases carry wr_reg
  assign w_rev_in = (r_state == S_ADDR) ? {r_cur_page, {(DW-PAGE_W){1'b0}}} : r_wr_reg;

  bit_reverse_n #(.W(DW)) u_rev (
    .i_d (w_rev_in),
    .o_q (w_rev_out)
  );

  // The gap cycle after every ptcl_done makes each request a fresh rising edge
  assign w_avail = w_in_phase && !r_gap;

  always_comb begin
    bus.token_pkt_out = '0;
    bus.data_pkt_out  = '0;
    if (w_avail) begin
      if (w_rd_data_phase) begin
        bus.token_pkt_out = make_token(PID_IN, DEV_ADDR, ENDP_DATA);
      end else begin
        bus.token_pkt_out = make_token(PID_OUT, DEV_ADDR, ENDP_ADDR);
        bus.data_pkt_out  = {PID_DATA0, w_rev_out};
      end
    end
  end

  assign bus.data_avail   = w_avail;
  assign bus.wr_ready     = r_state == S_WAIT_WR;
  assign bus.busy         = r_state != S_IDLE;
  assign bus.task_done    = r_state == S_DONE;
  assign bus.task_success = (r_state == S_DONE) && r_result;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.fail_count   = r_fail_cnt;

endmodule
